// File: rtl/ahb_multi_slave_ic.sv
// Single-master AHB-Lite interconnect: one-hot address decode, registered data-phase
// response mux, built-in ERROR default slave, and saturating error bookkeeping.

module ahb_ic_region_match #(
  parameter int                ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = '0,
  parameter logic [ADDR_W-1:0] MASK   = '0
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              match_o
);
  assign match_o = (addr_i & MASK) == BASE;
endmodule

module ahb_multi_slave_ic #(
  parameter int                             NUM_SLAVES = 4,
  parameter int                             ADDR_W     = 32,
  parameter int                             DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_BASE   = {NUM_SLAVES{32'h0}},
  parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLV_MASK   = {NUM_SLAVES{32'hFFFF_0000}}
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [2:0]                   hsize,
  input  logic [3:0]                   hprot,
  input  logic [DATA_W-1:0]            hwdata,
  output logic [DATA_W-1:0]            hr_data,
  output logic                         hready,
  output logic                         hresp,
  output logic [NUM_SLAVES-1:0]        hsel,
  output logic [ADDR_W-1:0]            Haddr,
  output logic [1:0]                   Htrans,
  output logic                         Hwrite,
  output logic [2:0]                   Hsize,
  output logic [3:0]                   Hprot,
  output logic [DATA_W-1:0]            Hwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_hrdata,
  input  logic [NUM_SLAVES-1:0]        slv_hreadyout,
  input  logic [NUM_SLAVES-1:0]        slv_hresp,
  output logic [7:0]                   err_count,
  output logic [ADDR_W-1:0]            err_addr
);

  typedef enum logic [1:0] {D_IDLE, D_ERR1, D_ERR2} dflt_state_e;

  logic [NUM_SLAVES-1:0] match;
  logic                  active, unmapped;
  logic [NUM_SLAVES-1:0] dsel_q;
  logic [ADDR_W-1:0]     daddr_q, err_addr_q;
  logic [7:0]            err_cnt_q;
  dflt_state_e           state_q, state_d;
  logic                  mux_rdy, mux_rsp;
  logic [DATA_W-1:0]     mux_dat;

  assign Haddr  = haddr;
  assign Htrans = htrans;
  assign Hwrite = hwrite;
  assign Hsize  = hsize;
  assign Hprot  = hprot;
  assign Hwdata = hwdata;

  // NONSEQ and SEQ both have htrans[1] set
  assign active = htrans[1];

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_match
    ahb_ic_region_match #(
      .ADDR_W (ADDR_W),
      .BASE   (SLV_BASE[g*ADDR_W +: ADDR_W]),
      .MASK   (SLV_MASK[g*ADDR_W +: ADDR_W])
    ) u_match (
      .addr_i  (haddr),
      .match_o (match[g])
    );
  end

  // Lowest-index region wins on overlap
  always_comb begin
    logic found;
    found = 1'b0;
    hsel  = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (active && match[i] && !found) begin
        hsel[i] = 1'b1;
        found   = 1'b1;
      end
    end
  end

  assign unmapped = active && (match == '0);

  always_comb begin
    mux_rdy = 1'b1;
    mux_rsp = 1'b0;
    mux_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dsel_q[i]) begin
        mux_rdy = slv_hreadyout[i];
        mux_rsp = slv_hresp[i];
        mux_dat = slv_hrdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Default slave overrides the mux; dsel_q is empty while it owns the data phase
  always_comb begin
    state_d = state_q;
    hready  = mux_rdy;
    hresp   = mux_rsp;
    hr_data = mux_dat;
    case (state_q)
      D_IDLE: if (mux_rdy && unmapped) state_d = D_ERR1;
      D_ERR1: begin
        hready  = 1'b0;
        hresp   = 1'b1;
        hr_data = '0;
        state_d = D_ERR2;
      end
      D_ERR2: begin
        hready  = 1'b1;
        hresp   = 1'b1;
        hr_data = '0;
        state_d = unmapped ? D_ERR1 : D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= D_IDLE;
      dsel_q     <= '0;
      daddr_q    <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (hready) begin
        dsel_q  <= hsel;
        daddr_q <= haddr;
      end
      if (hready && hresp) begin
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        err_addr_q <= daddr_q;
      end
    end
  end

  assign err_count = err_cnt_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ahb_multi_slave_ic.sv
// Directed and randomized bench for ahb_multi_slave_ic against a transfer-level model.

module tb_ahb_multi_slave_ic;

  localparam int NS = 4;
  localparam logic [1:0] IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11;

  logic            clk, rst_n;
  logic [31:0]     haddr, hwdata, hr_data, Haddr, Hwdata, err_addr;
  logic [1:0]      htrans, Htrans;
  logic            hwrite, Hwrite, hready, hresp;
  logic [2:0]      hsize, Hsize;
  logic [3:0]      hprot, Hprot, hsel;
  logic [NS*32-1:0] slv_hrdata;
  logic [NS-1:0]   slv_hreadyout, slv_hresp;
  logic [7:0]      err_count;

  ahb_multi_slave_ic #(
    .NUM_SLAVES (NS), .ADDR_W (32), .DATA_W (32),
    .SLV_BASE   ({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK   ({NS{32'hFFFF_0000}})
  ) dut (
    .clk (clk), .reset (rst_n),
    .haddr (haddr), .htrans (htrans), .hwrite (hwrite), .hsize (hsize),
    .hprot (hprot), .hwdata (hwdata),
    .hr_data (hr_data), .hready (hready), .hresp (hresp), .hsel (hsel),
    .Haddr (Haddr), .Htrans (Htrans), .Hwrite (Hwrite), .Hsize (Hsize),
    .Hprot (Hprot), .Hwdata (Hwdata),
    .slv_hrdata (slv_hrdata), .slv_hreadyout (slv_hreadyout), .slv_hresp (slv_hresp),
    .err_count (err_count), .err_addr (err_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Transfer-level model: who owns the data phase and how far along it is
  int          dp_kind;   // 0 none, 1 mapped slave, 2 unmapped
  int          dp_slv, dp_wait, dp_ph;
  logic        dp_resp;
  logic [31:0] dp_addr;
  int          ecnt;
  logic [31:0] eaddr;
  int          next_waits = 0;
  logic        next_resp  = 1'b0;
  logic        ovr_en     = 1'b0;
  logic [31:0] ovr_val    = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    case (a[31:16])
      16'h0000: return 0;
      16'h1000: return 1;
      16'h2000: return 2;
      16'h3000: return 3;
      default:  return -1;
    endcase
  endfunction

  task automatic step(input logic [31:0] a, input logic [1:0] t);
    logic [31:0] rd [NS];
    logic [NS-1:0] rdy, rsp;
    logic [3:0]  e_sel;
    logic        e_rdy, e_rsp, w;
    logic [31:0] e_dat, wd;
    logic [2:0]  sz;
    logic [3:0]  pr;
    int          idx;
    @(negedge clk);
    w = 1'($urandom); sz = 3'($urandom); pr = 4'($urandom); wd = $urandom;
    haddr = a; htrans = t; hwrite = w; hsize = sz; hprot = pr; hwdata = wd;
    for (int i = 0; i < NS; i++) begin
      rd[i] = $urandom; rdy[i] = 1'($urandom); rsp[i] = 1'($urandom);
    end
    if (dp_kind == 1) begin
      rdy[dp_slv] = (dp_wait == 0);
      rsp[dp_slv] = dp_resp && (dp_wait == 0);
      if (ovr_en) rd[dp_slv] = ovr_val;
    end
    for (int i = 0; i < NS; i++) slv_hrdata[i*32 +: 32] = rd[i];
    slv_hreadyout = rdy;
    slv_hresp     = rsp;

    idx   = region(a);
    e_sel = (t[1] && idx >= 0) ? 4'(1 << idx) : 4'b0000;
    case (dp_kind)
      1:       begin e_rdy = (dp_wait == 0); e_rsp = rsp[dp_slv]; e_dat = rd[dp_slv]; end
      2:       begin e_rdy = (dp_ph == 1);   e_rsp = 1'b1;        e_dat = '0; end
      default: begin e_rdy = 1'b1;           e_rsp = 1'b0;        e_dat = '0; end
    endcase
    #1;
    chk("hsel",      64'(hsel),      64'(e_sel));
    chk("Haddr",     64'(Haddr),     64'(a));
    chk("Htrans",    64'(Htrans),    64'(t));
    chk("Hctl",      64'({Hwrite, Hsize, Hprot, Hwdata}), 64'({w, sz, pr, wd}));
    chk("hready",    64'(hready),    64'(e_rdy));
    chk("hresp",     64'(hresp),     64'(e_rsp));
    chk("hr_data",   64'(hr_data),   64'(e_dat));
    chk("err_count", 64'(err_count), 64'(ecnt));
    chk("err_addr",  64'(err_addr),  64'(eaddr));

    // Effect of the coming rising edge
    if (e_rdy && e_rsp) begin
      if (ecnt < 255) ecnt++;
      eaddr = dp_addr;
    end
    if (e_rdy) begin
      dp_addr = a;
      if (!t[1])        dp_kind = 0;
      else if (idx < 0) begin dp_kind = 2; dp_ph = 0; end
      else begin
        dp_kind = 1; dp_slv = idx; dp_wait = next_waits; dp_resp = next_resp;
      end
    end else begin
      if (dp_kind == 1) dp_wait--;
      if (dp_kind == 2) dp_ph = 1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_hready",  64'(hready),    64'd1);
    chk("rst_hresp",   64'(hresp),     64'd0);
    chk("rst_hr_data", 64'(hr_data),   64'd0);
    chk("rst_errcnt",  64'(err_count), 64'd0);
    chk("rst_erradr",  64'(err_addr),  64'd0);
    dp_kind = 0; ecnt = 0; eaddr = '0; dp_addr = '0;
    haddr = 32'h8000_0000; htrans = NONSEQ;
    @(negedge clk);
    #1;
    chk("rst_hold_hready", 64'(hready), 64'd1);
    chk("rst_hold_hresp",  64'(hresp),  64'd0);
    rst_n = 1'b1; htrans = IDLE; haddr = '0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [7:0] top, mid;
    case ($urandom_range(0, 7))
      0: top = 8'h00; 1: top = 8'h10; 2: top = 8'h20; 3: top = 8'h30;
      4: top = 8'h40; 5: top = 8'h80; 6: top = 8'h90; default: top = 8'hFF;
    endcase
    mid = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
    return {top, mid, 16'($urandom)};
  endfunction

  initial begin
    rst_n = 1'b0; haddr = '0; htrans = IDLE; hwrite = 0; hsize = '0; hprot = '0;
    hwdata = '0; slv_hrdata = '0; slv_hreadyout = '1; slv_hresp = '0;
    dp_kind = 0; ecnt = 0; eaddr = '0; dp_addr = '0; dp_slv = 0; dp_wait = 0;
    dp_ph = 0; dp_resp = 0;
    do_reset();

    // Decode and single-cycle read from slave 1
    step(32'h1000_0004, NONSEQ);
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    step(32'h0, IDLE);
    ovr_en = 1'b0;

    // Slave 2 stalls 3 cycles; new address held during the stall
    next_waits = 3;
    step(32'h2000_0000, NONSEQ);
    next_waits = 0;
    repeat (4) step(32'h0000_0010, NONSEQ);
    step(32'h0, IDLE);

    // Unmapped access
    step(32'h8000_0000, NONSEQ);
    repeat (3) step(32'h0, IDLE);
    chk("unmapped_cnt",  64'(err_count), 64'd1);
    chk("unmapped_addr", 64'(err_addr),  64'h8000_0000);

    // Back-to-back unmapped: new transfer accepted during ERR2
    step(32'h9000_0000, NONSEQ);
    step(32'h9000_0000, NONSEQ);
    step(32'hA000_0000, NONSEQ);
    repeat (3) step(32'h0, IDLE);
    chk("b2b_cnt",  64'(err_count), 64'd3);
    chk("b2b_addr", 64'(err_addr),  64'hA000_0000);

    // Saturation through slave ERRORs
    next_resp = 1'b1;
    repeat (260) step(32'h0000_0100, NONSEQ);
    next_resp = 1'b0;
    repeat (2) step(32'h0, IDLE);
    chk("sat_cnt", 64'(err_count), 64'hFF);

    // IDLE and BUSY to a mapped address decode to nothing
    step(32'h1000_0000, IDLE);
    step(32'h2000_0000, BUSY);
    step(32'h0, IDLE);

    // Reset during a stalled slave read, then during default-slave ERR1
    next_waits = 3;
    step(32'h1000_0004, NONSEQ);
    step(32'h0, IDLE);
    next_waits = 0;
    do_reset();
    step(32'h0, IDLE);
    step(32'h8000_0000, NONSEQ);
    do_reset();
    step(32'h0, IDLE);

    // Randomized traffic
    repeat (400) begin
      logic [1:0] t;
      case ($urandom_range(0, 5))
        0: t = IDLE; 1: t = BUSY; 2, 3: t = NONSEQ; default: t = SEQ;
      endcase
      next_waits = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      next_resp  = ($urandom_range(0, 7) == 0);
      step(rand_addr(), t);
    end
    next_waits = 0; next_resp = 1'b0;
    repeat (6) step(32'h0, IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
